// File: rtl/fwd_pkg.sv
// Shared types and constants for the operand-forwarding scoreboard.
// The entry struct is sized by the default AW/LW constants.
package fwd_pkg;

    localparam int DEPTH_DEF = 3;
    localparam int NSRC_DEF  = 2;
    localparam int AW_DEF    = 5;
    localparam int LW_DEF    = 2;

    // Forward-select value meaning "read the register file".
    localparam int FWD_RF = 0;

    typedef enum logic [LW_DEF-1:0] {
        LAT_ALU  = LW_DEF'(0),
        LAT_LOAD = LW_DEF'(1)
    } lat_e;

    typedef struct packed {
        logic              valid;
        logic [AW_DEF-1:0] rd;
        logic              wen;
        logic [LW_DEF-1:0] lat;
    } entry_t;

endpackage

// File: rtl/fwd_scoreboard_if.sv
// ID-stage request, hazard and forwarding bundle between the pipeline control and the scoreboard.
interface fwd_scoreboard_if #(
    parameter int DEPTH = 3,
    parameter int NSRC  = 2,
    parameter int AW    = 5,
    parameter int LW    = 2,
    parameter int SW    = $clog2(DEPTH + 1)
);
    logic                    advance;
    logic                    flush;
    logic                    id_valid;
    logic [NSRC-1:0][AW-1:0] id_src;
    logic [NSRC-1:0]         id_use;
    logic [AW-1:0]           id_rd;
    logic                    id_wen;
    logic [LW-1:0]           id_lat;
    logic                    stall;
    logic [NSRC-1:0][SW-1:0] ex_fwd_sel;
    logic [15:0]             stall_cnt;

    modport master (
        output advance, flush, id_valid, id_src, id_use, id_rd, id_wen, id_lat,
        input  stall, ex_fwd_sel, stall_cnt
    );

    modport slave (
        input  advance, flush, id_valid, id_src, id_use, id_rd, id_wen, id_lat,
        output stall, ex_fwd_sel, stall_cnt
    );
endinterface

// File: rtl/fwd_entry_pipe.sv
// Producer shift register: entry k holds the instruction now in stage k (1=EX).
// Handles the plain shift, bubble insertion on a stall and the kill of ID/EX on a flush.
module fwd_entry_pipe
    import fwd_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEF
) (
    input  logic               CLK,
    input  logic               nRST,
    input  logic               advance,
    input  logic               flush,
    input  logic               bubble,
    input  entry_t             load,
    output entry_t [DEPTH:1]   ent
);

    entry_t [DEPTH:1] q;

    // NOTE: state registers use non-blocking assignments so every entry samples
    // its neighbour's pre-edge value; blocking here would ripple one value down the chain.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            q <= '0;
        end else if (advance) begin
            for (int k = DEPTH; k >= 2; k--) begin
                q[k] <= q[k-1];
            end
            if (flush) begin
                // The old EX instruction has just moved into entry 2; kill it there.
                q[1] <= '0;
                q[2] <= '0;
            end else if (bubble) begin
                q[1] <= '0;
            end else begin
                q[1] <= load;
            end
        end else if (flush) begin
            q[1] <= '0;
        end
    end

    assign ent = q;

endmodule

// File: rtl/fwd_scoreboard.sv
// Forwarding/hazard scoreboard: matches ID sources against in-flight producers,
// raises a load-use stall and registers the EX-stage forward selects.
module fwd_scoreboard
    import fwd_pkg::*;
#(
    parameter int  DEPTH = DEPTH_DEF,
    parameter int  NSRC  = NSRC_DEF,
    parameter int  AW    = AW_DEF,
    parameter int  LW    = LW_DEF,
    localparam int SW    = $clog2(DEPTH + 1)
) (
    input logic             CLK,
    input logic             nRST,
    fwd_scoreboard_if.slave bus
);

    entry_t [DEPTH:1]        ent;
    entry_t                  load;
    int                      win_k   [NSRC];
    logic [NSRC-1:0][LW-1:0] win_lat;
    logic [NSRC-1:0][SW-1:0] sel_next;
    logic [NSRC-1:0][SW-1:0] sel_q;
    logic [15:0]             cnt_q;
    logic                    hazard;
    logic                    stall_int;

    assign load = '{valid: bus.id_valid, rd: bus.id_rd, wen: bus.id_wen, lat: bus.id_lat};

    fwd_entry_pipe #(.DEPTH(DEPTH)) u_pipe (
        .CLK     (CLK),
        .nRST    (nRST),
        .advance (bus.advance),
        .flush   (bus.flush),
        .bubble  (stall_int),
        .load    (load),
        .ent     (ent)
    );

    // NOTE: every variable written here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    always_comb begin
        hazard   = 1'b0;
        sel_next = '0;
        win_lat  = '0;
        for (int s = 0; s < NSRC; s++) begin
            win_k[s] = 0;
            // Scan oldest to youngest so the youngest matching producer is kept.
            for (int k = DEPTH; k >= 1; k--) begin
                if (ent[k].valid && ent[k].wen && ent[k].rd != '0 &&
                    ent[k].rd == bus.id_src[s] && bus.id_use[s]) begin
                    win_k[s]   = k;
                    win_lat[s] = ent[k].lat;
                end
            end
            if (win_k[s] != 0) begin
                if (win_k[s] > int'(win_lat[s])) begin
                    sel_next[s] = (win_k[s] == DEPTH) ? SW'(FWD_RF) : SW'(win_k[s] + 1);
                end else begin
                    hazard = 1'b1;
                end
            end
        end
    end

    assign stall_int = nRST && bus.id_valid && !bus.flush && hazard;

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            sel_q <= '0;
            cnt_q <= '0;
        end else if (bus.advance) begin
            if (bus.flush || stall_int) begin
                sel_q <= '0;
            end else begin
                sel_q <= sel_next;
            end
            if (stall_int && cnt_q != 16'hFFFF) begin
                cnt_q <= cnt_q + 16'd1;
            end
        end
    end

    assign bus.stall      = stall_int;
    assign bus.ex_fwd_sel = sel_q;
    assign bus.stall_cnt  = cnt_q;

endmodule

// File: tb/tb_fwd_scoreboard.sv
// Bench for fwd_scoreboard: directed vector table, hand-written corner sequences,
// then random traffic against a queue-based model of the in-flight producers.
module tb_fwd_scoreboard;

    localparam int DEPTH = 3;

    logic CLK;
    logic nRST;
    int   total = 0;
    int   bad   = 0;

    fwd_scoreboard_if #(.DEPTH(DEPTH), .NSRC(2), .AW(5), .LW(2)) bus ();

    fwd_scoreboard #(.DEPTH(DEPTH), .NSRC(2), .AW(5), .LW(2)) dut (
        .CLK  (CLK),
        .nRST (nRST),
        .bus  (bus)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct {
        int adv, fl, vld, s0, s1, uses, rd, wen, lat;
        int e_stall, e_sel0, e_sel1, e_cnt;
    } vec_t;

    typedef struct {
        bit v;
        int rd;
        bit wen;
        int lat;
    } prod_t;

    prod_t pl[$];   // pl[0] is the producer in EX
    int    m_sel0, m_sel1, m_cnt;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic drive(input int adv, fl, vld, s0, s1, uses, rd, wen, lat);
        @(negedge CLK);
        bus.advance   = 1'(adv);
        bus.flush     = 1'(fl);
        bus.id_valid  = 1'(vld);
        bus.id_src[0] = 5'(s0);
        bus.id_src[1] = 5'(s1);
        bus.id_use    = 2'(uses);
        bus.id_rd     = 5'(rd);
        bus.id_wen    = 1'(wen);
        bus.id_lat    = 2'(lat);
        #1;
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic check_out(input string tag, input int s0, s1, cnt);
        check({tag, "_sel0"}, 32'(bus.ex_fwd_sel[0]), s0);
        check({tag, "_sel1"}, 32'(bus.ex_fwd_sel[1]), s1);
        check({tag, "_cnt"}, 32'(bus.stall_cnt), cnt);
    endtask

    function automatic void model_reset();
        prod_t inv = '{0, 0, 0, 0};
        pl.delete();
        for (int i = 0; i < DEPTH; i++) pl.push_back(inv);
        m_sel0 = 0;
        m_sel1 = 0;
        m_cnt  = 0;
    endfunction

    // Expected stall and next selects, straight from the forwarding rules.
    function automatic void model_eval(input int vld, fl, s0, s1, uses,
                                       output bit stl, output int ns0, output int ns1);
        int src[2];
        int ns[2];
        bit hz = 0;
        src[0] = s0;
        src[1] = s1;
        for (int s = 0; s < 2; s++) begin
            ns[s] = 0;
            if (uses[s]) begin
                for (int i = 0; i < pl.size(); i++) begin
                    if (pl[i].v && pl[i].wen && pl[i].rd != 0 && pl[i].rd == src[s]) begin
                        if (i + 1 > pl[i].lat) ns[s] = (i + 1 == DEPTH) ? 0 : i + 2;
                        else hz = 1;
                        break;
                    end
                end
            end
        end
        ns0 = ns[0];
        ns1 = ns[1];
        stl = (vld != 0) && (fl == 0) && hz;
    endfunction

    function automatic void model_step(input int adv, fl, vld, rd, wen, lat,
                                       input bit stl, input int ns0, ns1);
        prod_t inv = '{0, 0, 0, 0};
        prod_t nw;
        if (adv != 0) begin
            if (fl != 0) begin
                pl.push_front(inv);
                pl[1] = inv;
                m_sel0 = 0;
                m_sel1 = 0;
            end else if (stl) begin
                pl.push_front(inv);
                m_sel0 = 0;
                m_sel1 = 0;
                if (m_cnt < 65535) m_cnt++;
            end else begin
                nw = '{vld != 0, rd, wen != 0, lat};
                pl.push_front(nw);
                m_sel0 = ns0;
                m_sel1 = ns1;
            end
            void'(pl.pop_back());
        end else if (fl != 0) begin
            pl[0] = inv;
        end
    endfunction

    vec_t vt[17];

    initial begin
        vt[0]  = '{1,0,1,  0, 0,0,  3,1,0, 0,0,0,0};   // add $3
        vt[1]  = '{1,0,1,  3, 0,1,  6,1,0, 0,2,0,0};   // sub rs=$3 -> MEM
        vt[2]  = '{1,0,1,  0, 0,0,  4,1,1, 0,0,0,0};   // lw $4
        vt[3]  = '{1,0,1,  0, 4,2,  7,1,0, 1,0,0,1};   // load-use stall
        vt[4]  = '{1,0,1,  0, 4,2,  7,1,0, 0,0,3,1};   // retry -> WB
        vt[5]  = '{1,0,1,  0, 0,0,  5,1,0, 0,0,0,1};
        vt[6]  = '{1,0,1,  0, 0,0,  5,1,0, 0,0,0,1};
        vt[7]  = '{1,0,1,  5, 5,3,  0,1,0, 0,2,2,1};   // youngest $5 wins
        vt[8]  = '{1,0,1,  0, 5,3,  9,1,0, 0,0,3,1};   // $0 never forwards
        vt[9]  = '{1,0,1,  9, 0,0, 10,0,0, 0,0,0,1};   // unused source
        vt[10] = '{1,0,1, 10, 9,3, 12,1,0, 0,0,3,1};   // wen=0 producer ignored
        vt[11] = '{1,0,0,  0, 0,0, 11,1,0, 0,0,0,1};   // invalid ID instruction
        vt[12] = '{1,0,1, 11, 0,1, 13,1,0, 0,0,0,1};
        vt[13] = '{1,0,1, 12,13,3, 14,1,2, 0,0,2,1};   // WB wraps to RF; lat-2 producer
        vt[14] = '{1,0,1, 14, 0,1, 15,1,0, 1,0,0,2};
        vt[15] = '{1,0,1, 14, 0,1, 15,1,0, 1,0,0,3};
        vt[16] = '{1,0,1, 14, 0,1, 15,1,0, 0,0,0,3};

        nRST = 1'b0;
        bus.advance = 1'b0; bus.flush = 1'b0; bus.id_valid = 1'b1;
        bus.id_src = '0; bus.id_use = '1; bus.id_rd = '0; bus.id_wen = 1'b0; bus.id_lat = '0;
        #12;
        check("rst_stall", 32'(bus.stall), 0);
        check_out("rst", 0, 0, 0);
        @(negedge CLK);
        nRST = 1'b1;

        for (int i = 0; i < 17; i++) begin
            drive(vt[i].adv, vt[i].fl, vt[i].vld, vt[i].s0, vt[i].s1, vt[i].uses,
                  vt[i].rd, vt[i].wen, vt[i].lat);
            check($sformatf("t%0d_stall", i), 32'(bus.stall), vt[i].e_stall);
            tick();
            check_out($sformatf("t%0d", i), vt[i].e_sel0, vt[i].e_sel1, vt[i].e_cnt);
        end

        // Flush while a load-use hazard is pending.
        drive(1,0,1, 0,0,0, 21,1,0); tick();
        drive(1,0,1, 0,0,0, 20,1,1); tick();
        drive(1,1,1, 0,20,2, 20,1,0);
        check("fl_stall", 32'(bus.stall), 0);
        tick();
        check_out("fl", 0, 0, 3);
        drive(1,0,1, 21,20,3, 31,1,0);
        check("fl_after_stall", 32'(bus.stall), 0);
        tick();
        check_out("fl_after", 0, 0, 3);

        // Flush without advance kills only EX.
        drive(1,0,1, 31,0,1, 22,1,0); tick();
        check_out("fz_pre", 2, 0, 3);
        drive(0,1,1, 22,0,1, 23,1,0);
        check("fz_stall", 32'(bus.stall), 0);
        tick();
        check_out("fz_hold", 2, 0, 3);
        drive(1,0,1, 22,31,3, 40,1,0); tick();
        check_out("fz_after", 0, 3, 3);

        // Freeze in the middle of a load-use hazard.
        drive(1,0,1, 40,0,1, 23,1,1); tick();
        check_out("frz_pre", 2, 0, 3);
        for (int c = 0; c < 3; c++) begin
            drive(0,0,1, 0,23,2, 41,1,0);
            check($sformatf("frz%0d_stall", c), 32'(bus.stall), 1);
            tick();
            check_out($sformatf("frz%0d", c), 2, 0, 3);
        end
        drive(1,0,1, 0,23,2, 41,1,0);
        check("frz_go_stall", 32'(bus.stall), 1);
        tick();
        check_out("frz_go", 0, 0, 4);
        drive(1,0,1, 0,23,2, 41,1,0);
        check("frz_fwd_stall", 32'(bus.stall), 0);
        tick();
        check_out("frz_fwd", 0, 3, 4);

        // Asynchronous reset between edges with three live producers.
        drive(1,0,1, 0,0,0, 24,1,0); tick();
        drive(1,0,1, 0,0,0, 25,1,0); tick();
        drive(1,0,1, 25,0,1, 26,1,0); tick();
        check_out("ar_pre", 2, 0, 4);
        #2;
        nRST = 1'b0;
        #1;
        check("ar_stall", 32'(bus.stall), 0);
        check_out("ar", 0, 0, 0);
        nRST = 1'b1;
        drive(1,0,1, 26,25,3, 50,1,0);
        check("ar_after_stall", 32'(bus.stall), 0);
        tick();
        check_out("ar_after", 0, 0, 0);

        // Random traffic against the model.
        @(negedge CLK);
        nRST = 1'b0;
        #2;
        nRST = 1'b1;
        model_reset();
        for (int c = 0; c < 800; c++) begin
            int adv, fl, vld, s0, s1, uses, rd, wen, lat, ns0, ns1;
            bit stl;
            adv  = ($urandom_range(0, 9) < 8) ? 1 : 0;
            fl   = ($urandom_range(0, 9) == 0) ? 1 : 0;
            vld  = ($urandom_range(0, 7) != 0) ? 1 : 0;
            s0   = int'($urandom_range(0, 7));
            s1   = int'($urandom_range(0, 7));
            uses = int'($urandom_range(0, 3));
            rd   = int'($urandom_range(0, 7));
            wen  = ($urandom_range(0, 5) != 0) ? 1 : 0;
            lat  = int'($urandom_range(0, 2));
            drive(adv, fl, vld, s0, s1, uses, rd, wen, lat);
            model_eval(vld, fl, s0, s1, uses, stl, ns0, ns1);
            check($sformatf("r%0d_stall", c), 32'(bus.stall), 32'(stl));
            @(posedge CLK);
            model_step(adv, fl, vld, rd, wen, lat, stl, ns0, ns1);
            #1;
            check_out($sformatf("r%0d", c), m_sel0, m_sel1, m_cnt);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
